// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller slice.
// Contents: FSM state encodings, ALU operation classes, instruction opcode
// patterns and a classifier mapping an 11-bit opcode field to an
// instruction class.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_DTYPE  = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    IC_INVALID,
    IC_RTYPE,
    IC_LDUR,
    IC_STUR,
    IC_CBZ,
    IC_B
  } instr_class_e;

  // Full 11-bit opcodes
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // Branches only define a prefix; the low bits belong to the offset field.
  localparam logic [7:0]  OP_CBZ_PREFIX = 8'b10110100;
  localparam logic [5:0]  OP_B_PREFIX   = 6'b000101;

  function automatic instr_class_e classify(input logic [10:0] op);
    instr_class_e cls;
    cls = IC_INVALID;
    if (op[10:5] == OP_B_PREFIX) begin
      cls = IC_B;
    end else if (op[10:3] == OP_CBZ_PREFIX) begin
      cls = IC_CBZ;
    end else begin
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = IC_RTYPE;
        OP_LDUR:                        cls = IC_LDUR;
        OP_STUR:                        cls = IC_STUR;
        default:                        cls = IC_INVALID;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the controller and instruction/data memory.
//   imem_req   : controller -> imem, fetch request
//   imem_ready : imem -> controller, fetch done (sampled while imem_req=1)
//   mem_read   : controller -> dmem, load request
//   mem_write  : controller -> dmem, store request
//   dmem_ready : dmem -> controller, data access done
interface multicycle_controller_if;
  logic imem_req;
  logic imem_ready;
  logic mem_read;
  logic mem_write;
  logic dmem_ready;

  modport master (
    output imem_req, mem_read, mem_write,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, mem_read, mem_write,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// mem_wait_timer: counts consecutive wait cycles of a memory phase.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (phase entry)
//   tick       : one more cycle spent waiting (ready=0)
//   expired    : this tick brings the count to LIMIT
// expired is gated by tick, so a ready arriving in the limit cycle
// suppresses it and the phase completes normally.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = tick && (count_reg == CW'(LIMIT - 1));
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM of a multicycle LEGv8-style datapath.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   run          : 1 = keep executing, 0 = stop at next instruction boundary
//   opcode_bits  : instruction bits [31:21] from the instruction register
//   zero         : ALU zero flag (CBZ decision)
//   mem          : memory handshake bundle (imem_req/ready, mem_read/write,
//                  dmem_ready)
//   ir_write, pc_write, reg2_loc, uncondbranch, branch, mem_to_reg,
//   alu_src, reg_write, alu_op : datapath controls
//   busy, fault  : status; state : current state encoding
//   retired      : completed-instruction counter (wraps)
// Outputs decode the registered state and latched opcode; ir_write and
// pc_write additionally follow imem_ready/zero so a same-cycle ready or
// branch decision takes effect without an extra cycle.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [10:0]           opcode_bits,
  input  logic                  zero,
  multicycle_controller_if.master mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg2_loc,
  output logic                  uncondbranch,
  output logic                  branch,
  output logic                  mem_to_reg,
  output logic                  alu_src,
  output logic                  reg_write,
  output logic                  busy,
  output logic                  fault,
  output logic [1:0]            alu_op,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      retired
);

  state_e             state_reg, state_next;
  logic [10:0]        opcode_reg;
  logic [CNT_W-1:0]   retired_reg;
  logic               retire;
  instr_class_e       cls_decode, cls_exec;
  state_e             boundary_state;
  logic               in_fetch, in_mem, phase_ready;
  logic               wait_clear, wait_tick, wait_expired;

  // DECODE sees the freshly written IR; later states use the latched copy.
  assign cls_decode = classify(opcode_bits);
  assign cls_exec   = classify(opcode_reg);

  assign boundary_state = run ? ST_FETCH : ST_IDLE;

  assign in_fetch    = (state_reg == ST_FETCH);
  assign in_mem      = (state_reg == ST_MEM);
  assign phase_ready = in_fetch ? mem.imem_ready : mem.dmem_ready;
  assign wait_tick   = (in_fetch || in_mem) && !phase_ready;
  // Clear only on entry so a FETCH->FETCH wait keeps accumulating.
  assign wait_clear  = (state_next != state_reg) &&
                       ((state_next == ST_FETCH) || (state_next == ST_MEM));

  mem_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wait_clear),
    .tick    (wait_tick),
    .expired (wait_expired)
  );

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem.imem_ready)    state_next = ST_DECODE;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_DECODE: begin
        state_next = (cls_decode == IC_INVALID) ? ST_FAULT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (cls_exec)
          IC_RTYPE:        state_next = ST_WRITEBACK;
          IC_LDUR, IC_STUR: state_next = ST_MEM;
          IC_CBZ, IC_B: begin
            retire     = 1'b1;
            state_next = boundary_state;
          end
          default:         state_next = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        if (mem.dmem_ready) begin
          if (cls_exec == IC_LDUR) begin
            state_next = ST_WRITEBACK;
          end else begin
            retire     = 1'b1;
            state_next = boundary_state;
          end
        end else if (wait_expired) begin
          state_next = ST_FAULT;
        end
      end
      ST_WRITEBACK: begin
        retire     = 1'b1;
        state_next = boundary_state;
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      opcode_reg  <= '0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE) opcode_reg <= opcode_bits;
      if (retire) retired_reg <= retired_reg + 1'b1;
    end
  end

  // Output decode
  logic    imem_req_d, mem_read_d, mem_write_d;
  alu_op_e alu_op_sel;

  always_comb begin
    imem_req_d   = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg2_loc     = 1'b0;
    uncondbranch = 1'b0;
    branch       = 1'b0;
    mem_read_d   = 1'b0;
    mem_to_reg   = 1'b0;
    mem_write_d  = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    fault        = 1'b0;
    alu_op_sel   = ALU_DTYPE;
    case (state_reg)
      ST_FETCH: begin
        imem_req_d = 1'b1;
        ir_write   = mem.imem_ready;
        pc_write   = mem.imem_ready;
      end
      ST_DECODE: begin
        // STUR/CBZ read Rt through the second register port.
        reg2_loc = (cls_decode == IC_STUR) || (cls_decode == IC_CBZ);
      end
      ST_EXECUTE: begin
        case (cls_exec)
          IC_RTYPE: alu_op_sel = ALU_RTYPE;
          IC_LDUR, IC_STUR: begin
            alu_op_sel = ALU_DTYPE;
            alu_src    = 1'b1;
          end
          IC_CBZ: begin
            alu_op_sel = ALU_BRANCH;
            branch     = 1'b1;
            pc_write   = zero;
          end
          IC_B: begin
            uncondbranch = 1'b1;
            pc_write     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_read_d  = (cls_exec == IC_LDUR);
        mem_write_d = (cls_exec == IC_STUR);
        alu_op_sel  = ALU_DTYPE;
        alu_src     = 1'b1;
      end
      ST_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_exec == IC_LDUR);
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign busy          = (state_reg != ST_IDLE) && (state_reg != ST_FAULT);
  assign mem.imem_req  = imem_req_d;
  assign mem.mem_read  = mem_read_d;
  assign mem.mem_write = mem_write_d;
  assign alu_op        = alu_op_sel;
  assign state         = state_reg;
  assign retired       = retired_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
// The retired counter is narrowed to 8 bits so the wrap is reachable.
module tb_multicycle_controller;
  localparam int CW = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2,
                         S_EXE = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_FLT = 3'd6;

  // ctrl order: imem_req ir_write pc_write reg2_loc uncondbranch branch
  //             mem_read mem_to_reg mem_write alu_src reg_write busy fault
  localparam logic [12:0] C_IDLE   = 13'b0000000000000;
  localparam logic [12:0] C_FWAIT  = 13'b1000000000010;
  localparam logic [12:0] C_FDONE  = 13'b1110000000010;
  localparam logic [12:0] C_DEC    = 13'b0000000000010;
  localparam logic [12:0] C_DEC_R2 = 13'b0001000000010;
  localparam logic [12:0] C_EXR    = 13'b0000000000010;
  localparam logic [12:0] C_EXD    = 13'b0000000001010;
  localparam logic [12:0] C_CBZ_T  = 13'b0010010000010;
  localparam logic [12:0] C_CBZ_F  = 13'b0000010000010;
  localparam logic [12:0] C_EXB    = 13'b0010100000010;
  localparam logic [12:0] C_MEMR   = 13'b0000001001010;
  localparam logic [12:0] C_MEMW   = 13'b0000000011010;
  localparam logic [12:0] C_WBR    = 13'b0000000000110;
  localparam logic [12:0] C_WBL    = 13'b0000000100110;
  localparam logic [12:0] C_FAULT  = 13'b0000000000001;

  localparam logic [10:0] I_ADD  = 11'b10001011000;
  localparam logic [10:0] I_ORR  = 11'b10101010000;
  localparam logic [10:0] I_LDUR = 11'b11111000010;
  localparam logic [10:0] I_STUR = 11'b11111000000;
  localparam logic [10:0] I_CBZ  = 11'b10110100101;
  localparam logic [10:0] I_B    = 11'b00010110011;
  localparam logic [10:0] I_BAD  = 11'b11111111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic zero = 1'b0;
  logic [10:0] opcode_bits = '0;
  logic ir_write, pc_write, reg2_loc, uncondbranch, branch, mem_to_reg;
  logic alu_src, reg_write, busy, fault;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [CW-1:0] retired;

  multicycle_controller_if mem_if();

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(15), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode_bits(opcode_bits),
    .zero(zero), .mem(mem_if), .ir_write(ir_write), .pc_write(pc_write),
    .reg2_loc(reg2_loc), .uncondbranch(uncondbranch), .branch(branch),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .reg_write(reg_write),
    .busy(busy), .fault(fault), .alu_op(alu_op), .state(state),
    .retired(retired)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [12:0]   ctrl;
    logic [1:0]    aop;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  exp_t        mon_e;
  string       mon_tag;
  logic [12:0] mon_act;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {mem_if.imem_req, ir_write, pc_write, reg2_loc, uncondbranch,
                 branch, mem_if.mem_read, mem_to_reg, mem_if.mem_write,
                 alu_src, reg_write, busy, fault};
      checks++;
      if (state !== mon_e.st || mon_act !== mon_e.ctrl ||
          alu_op !== mon_e.aop || retired !== mon_e.ret) begin
        errors++;
        $display("FAIL %s: got state=%0d ctrl=%b alu_op=%b retired=%0d, expected state=%0d ctrl=%b alu_op=%b retired=%0d",
                 mon_tag, state, mon_act, alu_op, retired,
                 mon_e.st, mon_e.ctrl, mon_e.aop, mon_e.ret);
      end
    end
  end

  // One clock of stimulus plus the outputs expected during that clock.
  task automatic cyc(input string tag, input logic rs, input logic r,
                     input logic imr, input logic dmr, input logic z,
                     input logic [2:0] st, input logic [12:0] ctrl,
                     input logic [1:0] aop, input int unsigned ret);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rs;
    run = r;
    mem_if.imem_ready = imr;
    mem_if.dmem_ready = dmr;
    zero = z;
    e.st = st;
    e.ctrl = ctrl;
    e.aop = aop;
    e.ret = CW'(ret);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic t_rtype(input string tag, input logic [10:0] op, input int unsigned ret);
    opcode_bits = op;
    cyc({tag, "_fetch"}, 1, 1, 1, 0, 0, S_FETCH, C_FDONE, 2'b00, ret);
    cyc({tag, "_dec"},   1, 1, 0, 0, 0, S_DEC,   C_DEC,   2'b00, ret);
    cyc({tag, "_exe"},   1, 1, 0, 0, 0, S_EXE,   C_EXR,   2'b10, ret);
    cyc({tag, "_wb"},    1, 1, 0, 0, 0, S_WB,    C_WBR,   2'b00, ret);
    $display("txn %s retired as #%0d", tag, ret + 1);
  endtask

  task automatic t_cbz(input logic z, input int unsigned ret);
    opcode_bits = I_CBZ;
    cyc("cbz_fetch", 1, 1, 1, 0, 0, S_FETCH, C_FDONE, 2'b00, ret);
    cyc("cbz_dec",   1, 1, 0, 0, 0, S_DEC,   C_DEC_R2, 2'b00, ret);
    cyc("cbz_exe",   1, 1, 0, 0, z, S_EXE,   z ? C_CBZ_T : C_CBZ_F, 2'b01, ret);
    $display("txn cbz zero=%0d retired as #%0d", z, ret + 1);
  endtask

  task automatic t_b(input logic run_exec, input int unsigned ret);
    opcode_bits = I_B;
    cyc("b_fetch", 1, 1, 1, 0, 0, S_FETCH, C_FDONE, 2'b00, ret);
    cyc("b_dec",   1, 1, 0, 0, 0, S_DEC,   C_DEC,   2'b00, ret);
    cyc("b_exe",   1, run_exec, 0, 0, 0, S_EXE, C_EXB, 2'b00, ret);
    $display("txn b retired as #%0d", ret + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_if.imem_ready = 1'b0;
    mem_if.dmem_ready = 1'b0;

    // Reset state, then release with run=1: IDLE for the release cycle.
    cyc("rst_hold",    0, 1, 1, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    cyc("rst_release", 1, 1, 1, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    $display("txn reset released");

    t_rtype("add", I_ADD, 0);
    t_rtype("orr", I_ORR, 1);

    // LDUR with dmem_ready on the fourth MEM cycle.
    opcode_bits = I_LDUR;
    cyc("ldur_fetch", 1, 1, 1, 0, 0, S_FETCH, C_FDONE, 2'b00, 2);
    cyc("ldur_dec",   1, 1, 0, 0, 0, S_DEC,   C_DEC,   2'b00, 2);
    cyc("ldur_exe",   1, 1, 0, 0, 0, S_EXE,   C_EXD,   2'b00, 2);
    for (int i = 0; i < 3; i++)
      cyc("ldur_mem_wait", 1, 1, 0, 0, 0, S_MEM, C_MEMR, 2'b00, 2);
    cyc("ldur_mem_done", 1, 1, 0, 1, 0, S_MEM, C_MEMR, 2'b00, 2);
    cyc("ldur_wb",    1, 1, 0, 0, 0, S_WB,    C_WBL,   2'b00, 2);
    $display("txn ldur retired as #3");

    t_cbz(1'b1, 3);
    t_cbz(1'b0, 4);

    // STUR after two fetch waits; reset lands while mem_write is held.
    opcode_bits = I_STUR;
    cyc("stur_fwait",  1, 1, 0, 0, 0, S_FETCH, C_FWAIT, 2'b00, 5);
    cyc("stur_fwait",  1, 1, 0, 0, 0, S_FETCH, C_FWAIT, 2'b00, 5);
    cyc("stur_fetch",  1, 1, 1, 0, 0, S_FETCH, C_FDONE, 2'b00, 5);
    cyc("stur_dec",    1, 1, 0, 0, 0, S_DEC,   C_DEC_R2, 2'b00, 5);
    cyc("stur_exe",    1, 1, 0, 0, 0, S_EXE,   C_EXD,   2'b00, 5);
    cyc("stur_mem",    1, 1, 0, 0, 0, S_MEM,   C_MEMW,  2'b00, 5);
    cyc("stur_async_rst", 0, 1, 0, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    cyc("rst_release", 1, 1, 0, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    $display("txn stur aborted by reset");

    // Ready arriving on the 15th fetch cycle wins; bad opcode then faults.
    opcode_bits = I_BAD;
    for (int i = 0; i < 14; i++)
      cyc("late_fwait", 1, 1, 0, 0, 0, S_FETCH, C_FWAIT, 2'b00, 0);
    cyc("late_fetch",  1, 1, 1, 0, 0, S_FETCH, C_FDONE, 2'b00, 0);
    cyc("bad_dec",     1, 1, 0, 0, 0, S_DEC,   C_DEC,   2'b00, 0);
    cyc("bad_fault",   1, 1, 1, 1, 0, S_FLT,   C_FAULT, 2'b00, 0);
    cyc("bad_sticky",  1, 1, 1, 1, 0, S_FLT,   C_FAULT, 2'b00, 0);
    $display("txn illegal opcode faulted");

    // Fetch timeout: 15 cycles without imem_ready.
    cyc("rst_hold",    0, 1, 0, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    cyc("rst_release", 1, 1, 0, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    for (int i = 0; i < 15; i++)
      cyc("to_fwait", 1, 1, 0, 0, 0, S_FETCH, C_FWAIT, 2'b00, 0);
    cyc("to_fault",    1, 1, 1, 0, 0, S_FLT, C_FAULT, 2'b00, 0);
    cyc("to_sticky",   1, 1, 1, 0, 0, S_FLT, C_FAULT, 2'b00, 0);
    $display("txn fetch timeout faulted");

    // Counter wrap: 256 B instructions; run drops during the last EXECUTE.
    cyc("rst_hold",    0, 1, 0, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    cyc("rst_release", 1, 1, 0, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    for (int k = 0; k < 255; k++) t_b(1'b1, k);
    t_b(1'b0, 255);
    cyc("stop_idle",   1, 0, 0, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    cyc("stop_idle",   1, 0, 1, 0, 0, S_IDLE, C_IDLE, 2'b00, 0);
    $display("txn run=0 stop in idle");

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum consecutive wait cycles on a memory request before a fault.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 Clocking: clk is the single clock; rst_n is asynchronous, active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 run  in  1  1 = fetch and execute; 0 = stop at the next instruction boundary.
REQ-007 opcode_bits  in  11  instruction bits [31:21] from the instruction register.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 imem_ready  in  1  instruction memory done; sampled while imem_req=1.
REQ-010 dmem_ready  in  1  data memory done; sampled while mem_read or mem_write=1.
REQ-011 Outputs, 1 bit each: imem_req, ir_write, pc_write, reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, busy, fault.
REQ-012 alu_op  out  2  ALU operation class.
REQ-013 state  out  3  current state encoding.
REQ-014 retired  out  CNT_W  count of completed instructions.

Function
REQ-015 States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, FAULT=6; all outputs are registered-state decodes (Moore), except ir_write and pc_write (REQ-017, REQ-020), which also depend on ready and zero.
REQ-016 IDLE: all control outputs 0; go to FETCH when run=1.
REQ-017 FETCH: imem_req=1; when imem_ready=1, ir_write=1 and pc_write=1 in that cycle, then go to DECODE.
REQ-018 A same-cycle ready completes the phase in one cycle; there is no minimum wait.
REQ-019 DECODE (1 cycle):
  - latch opcode_bits internally;
  - reg2_loc=1 for STUR/CBZ;
  - ADD, SUB, AND, ORR, LDUR, STUR, CBZ, B go to EXECUTE;
  - any other opcode goes to FAULT.
REQ-020 EXECUTE (1 cycle):
  - R-type: alu_op=RTYPE(10), alu_src=0, then WRITEBACK.
  - LDUR/STUR: alu_op=DTYPE(00), alu_src=1, then MEM.
  - CBZ: alu_op=BRANCH(01), branch=1, pc_write=zero.
  - B: uncondbranch=1, pc_write=1.
  - CBZ and B then go to the boundary.
REQ-021 MEM: hold mem_read=1 (LDUR) or mem_write=1 (STUR) and alu_op=DTYPE, alu_src=1 until dmem_ready=1; LDUR then goes to WRITEBACK, STUR goes to the boundary.
REQ-022 WRITEBACK (1 cycle): reg_write=1; mem_to_reg=1 only for LDUR; then the boundary.
REQ-023 Boundary: increment retired by 1, wrapping from max to 0; go to FETCH if run=1, else IDLE.
REQ-024 Wait counter:
  - clears on entry to FETCH/MEM;
  - increments each cycle ready=0;
  - reaching TIMEOUT_CYCLES without ready goes to FAULT;
  - ready in the same cycle the counter reaches the limit wins.
REQ-025 FAULT: fault=1, all other control outputs 0; sticky until reset.
REQ-026 busy=1 in every state except IDLE and FAULT.
REQ-027 run deasserting mid-instruction does not abort; the instruction completes and retires.

Reset
REQ-028 rst_n=0 asynchronously forces state=IDLE, the latched opcode to 0, the wait counter to 0, retired to 0, and every output to 0, including mid-MEM with a request pending.
REQ-029 Leaving reset: the first FETCH occurs no earlier than the first rising edge with rst_n=1 and run=1.

Structure
REQ-030 Opcode patterns (CBZ 10110100xxx, B 000101xxxxx), ALUOp codes, and state encodings reside in the shared definitions.vh.
REQ-031 The wait counter and limit compare are a sub-module mem_wait_timer (inputs clear, tick; output expired).

Verification
REQ-032 ADD (10001011000), imem_ready=1 immediately -> FETCH, DECODE, EXECUTE (alu_op=10), WRITEBACK (reg_write=1); 4 cycles; retired=1.
REQ-033 LDUR (11111000010), dmem_ready after 3 cycles -> mem_read held 4 cycles, then mem_to_reg=1 and reg_write=1; 8 cycles total.
REQ-034 CBZ with zero=1, then zero=0 -> pc_write=1 in EXECUTE on the first only; branch=1 on both; retired=2.
REQ-035 imem_ready held 0 -> FAULT after 15 wait cycles, fault=1; an opcode of 11111111111 -> FAULT from DECODE.
REQ-036 rst_n=0 while STUR is in MEM with mem_write=1 -> mem_write=0 before the next edge, state=0, retired=0.
REQ-037 run=0 asserted during EXECUTE of B -> instruction retires, then IDLE with busy=0; retired wraps 0xFFFF to 0x0000 on the next retire.
